// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
package usb_tx_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} tx_state_t;

    localparam logic [7:0]  SYNC_BYTE    = 8'h80;
    localparam int unsigned STUFF_LIMIT  = 6;
    localparam int unsigned EOP_SE0_BITS = 2;

    typedef enum logic [1:0] {J, K, SE0} line_t;

    // Returns {d_plus, d_minus} for a bus line state.
    function automatic logic [1:0] line_pins(line_t l);
        case (l)
            J:       line_pins = 2'b10;
            K:       line_pins = 2'b01;
            default: line_pins = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time divider: strobes on the last clk cycle of every USB bit period.
module usb_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic bit_strobe
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (clear || bit_strobe) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_strobe = (cnt_q == LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, NRZI, bit stuffing and EOP onto registered D+/D-.
// Optional output-enable port d_oe is built when USB_TX_OE_EN is defined.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
`ifdef USB_TX_OE_EN
    output logic       d_oe,
`endif
    output logic       tx_err
);

    localparam logic [2:0] STUFF_MAX = 3'(STUFF_LIMIT);
    localparam logic [1:0] EOP_LAST  = 2'(EOP_SE0_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_q, ones_d;
    logic [1:0] eop_cnt_q, eop_cnt_d;
    logic [1:0] pins_q, pins_d;
    logic       last_q, last_d;
    logic       nrzi_q, nrzi_d;  // 1 = J level
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       bit_strobe;
    logic       send;
    logic       send_bit;

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (state_q == IDLE),
        .bit_strobe(bit_strobe)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        eop_cnt_d = eop_cnt_q;
        pins_d    = pins_q;
        last_d    = last_q;
        nrzi_d    = nrzi_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tx_ready  = 1'b0;
        send      = 1'b0;
        send_bit  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d   = SYNC;
                    shift_d   = SYNC_BYTE;
                    bit_cnt_d = 3'd0;
                    last_d    = 1'b0;
                    ones_d    = 3'd0;
                    send      = 1'b1;
                    send_bit  = SYNC_BYTE[0];
                end
            end
            SYNC, DATA: begin
                if (bit_strobe) begin
                    if (ones_q == STUFF_MAX) begin
                        // Stuff bit: shift register holds its position.
                        send     = 1'b1;
                        send_bit = 1'b0;
                    end else if (bit_cnt_q != 3'd7) begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        send      = 1'b1;
                        send_bit  = shift_q[1];
                    end else if (last_q) begin
                        state_d   = EOP_SE0;
                        eop_cnt_d = 2'd0;
                        nrzi_d    = 1'b1;
                        pins_d    = line_pins(SE0);
                    end else if (tx_valid) begin
                        tx_ready  = 1'b1;
                        state_d   = DATA;
                        shift_d   = tx_data;
                        last_d    = tx_last;
                        bit_cnt_d = 3'd0;
                        send      = 1'b1;
                        send_bit  = tx_data[0];
                    end else begin
                        err_d     = 1'b1;
                        state_d   = EOP_SE0;
                        eop_cnt_d = 2'd0;
                        nrzi_d    = 1'b1;
                        pins_d    = line_pins(SE0);
                    end
                end
            end
            EOP_SE0: begin
                if (bit_strobe) begin
                    if (eop_cnt_q == EOP_LAST) begin
                        state_d = EOP_J;
                        pins_d  = line_pins(J);
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
            end
            EOP_J: begin
                if (bit_strobe) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                nrzi_d  = 1'b1;
                pins_d  = line_pins(J);
            end
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it.
        if (send) begin
            nrzi_d = send_bit ? nrzi_q : ~nrzi_q;
            ones_d = send_bit ? (ones_q + 3'd1) : 3'd0;
            pins_d = nrzi_d ? line_pins(J) : line_pins(K);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            ones_q    <= 3'd0;
            eop_cnt_q <= 2'd0;
            pins_q    <= 2'b10;
            last_q    <= 1'b0;
            nrzi_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            eop_cnt_q <= eop_cnt_d;
            pins_q    <= pins_d;
            last_q    <= last_d;
            nrzi_q    <= nrzi_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef USB_TX_OE_EN
    logic oe_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            oe_q <= 1'b0;
        end else begin
            oe_q <= (state_d != IDLE);
        end
    end

    assign d_oe = oe_q;
`endif

    assign d_plus  = pins_q[1];
    assign d_minus = pins_q[0];
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;
    assign tx_err  = err_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line symbols, stuffing, underrun, back-to-back and reset.
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_err;
`ifdef USB_TX_OE_EN
    logic       d_oe;
    int         oe_bad;
`endif

    int checks = 0;
    int failures = 0;

    logic [1:0] samp[$];
    int         start_c, done_c, nready, nerr, busy_at_done, done_cnt;
    logic [7:0] pkt[4];
    int         pkt_n;
    logic       last_final;
    logic       hold;

    usb_tx_encoder #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .d_plus  (d_plus),
        .d_minus (d_minus),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
`ifdef USB_TX_OE_EN
        .d_oe    (d_oe),
`endif
        .tx_err  (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input string exp);
        string s;
        int    i;
        s = "";
        for (int k = 0; k < exp.len(); k++) begin
            i = start_c + k * CPB + CPB / 2;
            if (start_c >= 0 && i < samp.size()) begin
                case (samp[i])
                    2'b10:   s = {s, "J"};
                    2'b01:   s = {s, "K"};
                    2'b00:   s = {s, "0"};
                    default: s = {s, "X"};
                endcase
            end
        end
        checks++;
        assert (s == exp) else begin
            failures++;
            $error("FAIL %s observed=%s expected=%s", tag, s, exp);
        end
    endtask

    // Drives pkt[] byte by byte on tx_ready and records the line once per cycle until tx_done.
    task automatic run_pkt(input int budget);
        int   idx;
        logic adv;
        idx = 0;
        samp.delete();
        start_c = -1;
        done_c = -1;
        nready = 0;
        nerr = 0;
        busy_at_done = 1;
`ifdef USB_TX_OE_EN
        oe_bad = 0;
`endif
        tx_data  = pkt[0];
        tx_last  = (pkt_n == 1) && last_final;
        tx_valid = 1'b1;
        for (int c = 0; c < budget && done_c < 0; c++) begin
            @(negedge clk);
            samp.push_back({d_plus, d_minus});
            if (start_c < 0 && d_minus) start_c = c;
            if (tx_err) nerr++;
            if (tx_done) begin
                done_c = c;
                busy_at_done = tx_busy;
            end
`ifdef USB_TX_OE_EN
            if (d_oe !== tx_busy) oe_bad++;
`endif
            adv = tx_ready;
            @(posedge clk);
            #1;
            if (adv) begin
                nready++;
                idx++;
                if (idx < pkt_n) begin
                    tx_data = pkt[idx];
                    tx_last = (idx == pkt_n - 1) && last_final;
                end else if (!hold) begin
                    tx_valid = 1'b0;
                end
            end
        end
        check("done_seen", done_c >= 0, 1);
`ifdef USB_TX_OE_EN
        check("oe_tracks_busy", oe_bad, 0);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_dp", d_plus, 1);
        check("rst_dm", d_minus, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_ready", tx_ready, 0);
`ifdef USB_TX_OE_EN
        check("rst_oe", d_oe, 0);
`endif
        #2 n_rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_dp", d_plus, 1);

        // Single byte A5
        pkt[0] = 8'hA5; pkt_n = 1; last_final = 1'b1; hold = 1'b0;
        run_pkt(400);
        check_line("a5_line", "KJKJKJKKKJJKJJKK00J");
        check("a5_ready", nready, 1);
        check("a5_latency", done_c - start_c, 19 * CPB);
        check("a5_err", nerr, 0);
        check("a5_busy_at_done", busy_at_done, 0);

        // FF FF: stuffing inside each byte and across the boundary
        pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt_n = 2; last_final = 1'b1; hold = 1'b0;
        run_pkt(500);
        check_line("ffff_line", "KJKJKJKKKKKKKJJJJJJJKKKKKK00J");
        check("ffff_ready", nready, 2);
        check("ffff_latency", done_c - start_c, 29 * CPB);

        // 3F: SYNC's trailing 1 counts toward the run
        pkt[0] = 8'h3F; pkt_n = 1; last_final = 1'b1; hold = 1'b0;
        run_pkt(400);
        check_line("3f_line", "KJKJKJKKKKKKKJJKJ00J");
        check("3f_latency", done_c - start_c, 20 * CPB);

        // FC: stuff bit owed after the final data bit precedes EOP
        pkt[0] = 8'hFC; pkt_n = 1; last_final = 1'b1; hold = 1'b0;
        run_pkt(400);
        check_line("fc_line", "KJKJKJKKJKKKKKKKJ00J");
        check("fc_latency", done_c - start_c, 20 * CPB);

        // 00 without tx_last, then underrun
        pkt[0] = 8'h00; pkt_n = 1; last_final = 1'b0; hold = 1'b0;
        run_pkt(400);
        check_line("urun_line", "KJKJKJKKJKJKJKJK00J");
        check("urun_err", nerr, 1);
        check("urun_ready", nready, 1);
        check("urun_latency", done_c - start_c, 19 * CPB);

        // Back-to-back with tx_valid held
        pkt[0] = 8'hA5; pkt_n = 1; last_final = 1'b1; hold = 1'b1;
        run_pkt(400);
        check_line("b2b_line", "KJKJKJKKKJJKJJKK00J");
        check("b2b_busy_at_done", busy_at_done, 0);
        @(negedge clk);
        check("b2b_second_sync_dm", d_minus, 1);
        check("b2b_second_busy", tx_busy, 1);
`ifdef USB_TX_OE_EN
        check("b2b_second_oe", d_oe, 1);
`endif

        // Reset mid-packet
        repeat (20) @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_dp", d_plus, 1);
        check("mid_rst_dm", d_minus, 0);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_done", tx_done, 0);
        tx_valid = 1'b0;
        #1 n_rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_done) done_cnt++;
        end
        check("post_rst_no_done", done_cnt, 0);
        check("post_rst_busy", tx_busy, 0);
        check("post_rst_dp", d_plus, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
